retire_free_list: RTL and testbench
===================================

RETIRE_FREE_LIST -- requirements
Module: retire_free_list

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, total physical registers and free-list depth.
REQ-002 SHALL have parameter NUM_ARCH, default 32, architectural registers mapped at reset (p0..p31).
REQ-003 SHALL have parameter PREG_W, default 6, physical register address width.
REQ-004 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  synchronous reset, active-low.
REQ-006 SHALL have port i_retire_rob_rows [0:1]  input  rob_row_struct  retired ROB rows from COMPLETE, slot 0 older.
REQ-007 SHALL have port i_alloc_req [0:1]  input  1 each  rename requests for a free physical register, slot 0 priority.
REQ-008 SHALL have port o_alloc_valid [0:1]  output  1 each  allocation granted.
REQ-009 SHALL have port o_alloc_preg [0:1]  output  PREG_W each  granted physical register.
REQ-010 SHALL have port o_prf_we [0:1]  output  1 each  physical register file write enable.
REQ-011 SHALL have port o_prf_waddr [0:1]  output  PREG_W each  PRF write address.
REQ-012 SHALL have port o_prf_wdata [0:1]  output  32 each  PRF write data.
REQ-013 SHALL have port o_free_count  output  PREG_W+1  free-list occupancy.
REQ-014 SHALL have port o_overflow  output  1  sticky error: free-list push dropped.
REQ-015 SHALL have port o_retired_total  output  32  count of retired instructions, wrapping.

Function
REQ-016 SHALL treat a retire slot as live only when valid===1 and complete===1; X or 0 on either ignores the slot.
REQ-017 SHALL, for each live slot with RegWrite===1, drive o_prf_we=1, o_prf_waddr=PRegAddrDst, o_prf_wdata=data the cycle after the slot is presented (1-cycle registered latency).
REQ-018 SHALL drive o_prf_we=0 for non-live slots or RegWrite!=1; waddr/wdata then hold previous values.
REQ-019 SHALL push OldPRegAddrDst into the free list for each live slot with RegWrite===1 and OldPRegAddrDst!=0; p0 is never freed.
REQ-020 SHALL push slot 0 before slot 1 when both push in the same cycle.
REQ-021 SHALL implement the free list as a circular buffer of NUM_PREGS entries with head, tail and count; pointers wrap from NUM_PREGS-1 to 0.
REQ-022 SHALL grant requests in slot order using the count at cycle start: count>=2 grants both; count==1 grants the lowest-index requester only; count==0 grants none.
REQ-023 SHALL, when only slot 1 requests, grant slot 1 from the head entry.
REQ-024 SHALL register grants: o_alloc_valid/o_alloc_preg update the cycle after i_alloc_req; o_alloc_valid=0 for ungranted slots.
REQ-025 SHALL not bypass same-cycle pushes to pops; a register freed in cycle N is allocatable no earlier than cycle N+1.
REQ-026 SHALL update count_next = count - pops + pushes; o_free_count reflects registered count.
REQ-027 SHALL drop any push that would make count exceed NUM_PREGS (slot 1 dropped first) and set o_overflow=1 until reset.
REQ-028 SHALL increment o_retired_total by the number of live slots (0, 1 or 2) each cycle, wrapping modulo 2^32.
REQ-029 SHALL ignore MemWrite and MemtoReg; store commit belongs to the LSU.

Reset
REQ-030 SHALL, on i_clk edge with i_rst_n=0, load entry i with NUM_ARCH+i for i<NUM_PREGS-NUM_ARCH, set head=0, tail=NUM_PREGS-NUM_ARCH, count=NUM_PREGS-NUM_ARCH (32).
REQ-031 SHALL during reset clear o_alloc_valid, o_prf_we, o_prf_waddr, o_prf_wdata, o_overflow, o_retired_total to 0.
REQ-032 SHALL give reset priority over simultaneous retire and allocate; inputs in the reset cycle have no effect.

Verification
REQ-033 Reset then alloc_req={1,1} -> next cycle o_alloc_preg={32,33}, valid={1,1}, o_free_count=30.
REQ-034 Retire slot0 {valid=1,complete=1,RegWrite=1,PRegAddrDst=40,OldPRegAddrDst=5,data=0xDEAD} -> next cycle o_prf_we[0]=1, waddr=40, wdata=0xDEAD, free_count+1, retired_total+1.
REQ-035 Drain to free_count=1, alloc_req={1,1} -> only slot 0 granted; same cycle retire freeing p7 -> p7 granted only on the following cycle's request.
REQ-036 Retire with complete=0, valid=X, or OldPRegAddrDst=0 -> no PRF write (first two), no push, count unchanged.
REQ-037 Allocate 64 entries across the pointer wrap while freeing -> grant order matches push order across index 63->0; count never negative.
REQ-038 Free list full (count=64) plus two pushes -> both dropped, o_overflow=1 and held; assert i_rst_n=0 mid-traffic -> count=32, overflow=0.

Source files
------------

// File: rtl/retire_free_list_if.sv
// Retire-row record plus the retire/allocate bus between COMPLETE, rename and the free list.
package retire_free_list_pkg;
    localparam int ROB_PREG_W = 6;

    typedef struct packed {
        logic                  valid;
        logic                  complete;
        logic                  RegWrite;
        logic                  MemWrite;
        logic                  MemtoReg;
        logic [ROB_PREG_W-1:0] PRegAddrDst;
        logic [ROB_PREG_W-1:0] OldPRegAddrDst;
        logic [31:0]           data;
    } rob_row_struct;
endpackage

interface retire_free_list_if #(parameter int PREG_W = 6);
    import retire_free_list_pkg::*;

    rob_row_struct               i_retire_rob_rows [0:1];
    logic [1:0]                  i_alloc_req;
    logic [1:0]                  o_alloc_valid;
    logic [1:0][PREG_W-1:0]      o_alloc_preg;
    logic [1:0]                  o_prf_we;
    logic [1:0][PREG_W-1:0]      o_prf_waddr;
    logic [1:0][31:0]            o_prf_wdata;
    logic [PREG_W:0]             o_free_count;
    logic                        o_overflow;
    logic [31:0]                 o_retired_total;

    modport slave (
        input  i_retire_rob_rows, i_alloc_req,
        output o_alloc_valid, o_alloc_preg, o_prf_we, o_prf_waddr, o_prf_wdata,
               o_free_count, o_overflow, o_retired_total
    );

    modport master (
        output i_retire_rob_rows, i_alloc_req,
        input  o_alloc_valid, o_alloc_preg, o_prf_we, o_prf_waddr, o_prf_wdata,
               o_free_count, o_overflow, o_retired_total
    );
endinterface

// File: rtl/retire_free_list.sv
// Two-wide retire stage: writes results to the PRF, returns old mappings to a circular
// free list, and hands out free physical registers to rename.

module retire_free_list_lane
    import retire_free_list_pkg::*;
(
    input  rob_row_struct row,
    output logic          live,
    output logic          wr,
    output logic          push
);
    // Stores commit in the LSU, so the memory flags play no part here.
    logic unused_mem;
    assign unused_mem = row.MemWrite ^ row.MemtoReg;

    assign live = (row.valid === 1'b1) && (row.complete === 1'b1);
    assign wr   = live && (row.RegWrite === 1'b1);
    assign push = wr && (row.OldPRegAddrDst != '0);
endmodule

module retire_free_list
    import retire_free_list_pkg::*;
#(
    parameter int NUM_PREGS = 64,
    parameter int NUM_ARCH  = 32,
    parameter int PREG_W    = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    retire_free_list_if.slave  bus
);
    localparam int             CW        = PREG_W + 1;
    localparam logic [CW-1:0]  DEPTH     = CW'(NUM_PREGS);
    localparam logic [CW-1:0]  RESET_CNT = CW'(NUM_PREGS - NUM_ARCH);

    logic [PREG_W-1:0] fl [NUM_PREGS];
    logic [PREG_W-1:0] head, tail;
    logic [CW-1:0]     count;

    logic [1:0] live, wr, push, gnt, acc;
    logic [PREG_W-1:0] preg0, preg1, head_inc, tail_inc, push1_at;
    logic [CW-1:0] pops, pushes, avail;
    logic drop;

    function automatic logic [PREG_W-1:0] wrap_inc(input logic [PREG_W-1:0] p);
        return (p == PREG_W'(NUM_PREGS - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        retire_free_list_lane u_lane (
            .row  (bus.i_retire_rob_rows[g]),
            .live (live[g]),
            .wr   (wr[g]),
            .push (push[g])
        );
    end

    // Grants see only the cycle-start count; this cycle's pushes are not bypassed.
    always_comb begin
        gnt[0]   = bus.i_alloc_req[0] && (count >= CW'(1));
        gnt[1]   = bus.i_alloc_req[1] && (count >= (gnt[0] ? CW'(2) : CW'(1)));
        head_inc = wrap_inc(head);
        preg0    = fl[head];
        preg1    = gnt[0] ? fl[head_inc] : fl[head];
        pops     = CW'(gnt[0]) + CW'(gnt[1]);

        avail    = DEPTH - count + pops;
        acc[0]   = push[0] && (avail >= CW'(1));
        acc[1]   = push[1] && (avail >= (acc[0] ? CW'(2) : CW'(1)));
        drop     = (push[0] && !acc[0]) || (push[1] && !acc[1]);
        pushes   = CW'(acc[0]) + CW'(acc[1]);
        tail_inc = wrap_inc(tail);
        push1_at = acc[0] ? tail_inc : tail;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_PREGS; i++)
                fl[i] <= (i < NUM_PREGS - NUM_ARCH) ? PREG_W'(NUM_ARCH + i) : '0;
            head                <= '0;
            tail                <= PREG_W'(NUM_PREGS - NUM_ARCH);
            count               <= RESET_CNT;
            bus.o_alloc_valid   <= '0;
            bus.o_alloc_preg    <= '0;
            bus.o_prf_we        <= '0;
            bus.o_prf_waddr     <= '0;
            bus.o_prf_wdata     <= '0;
            bus.o_overflow      <= 1'b0;
            bus.o_retired_total <= '0;
        end else begin
            if (acc[0]) fl[tail]     <= bus.i_retire_rob_rows[0].OldPRegAddrDst;
            if (acc[1]) fl[push1_at] <= bus.i_retire_rob_rows[1].OldPRegAddrDst;

            case (pops)
                CW'(2):  head <= wrap_inc(head_inc);
                CW'(1):  head <= head_inc;
                default: head <= head;
            endcase
            case (pushes)
                CW'(2):  tail <= wrap_inc(tail_inc);
                CW'(1):  tail <= tail_inc;
                default: tail <= tail;
            endcase
            count <= count - pops + pushes;

            bus.o_alloc_valid <= gnt;
            if (gnt[0]) bus.o_alloc_preg[0] <= preg0;
            if (gnt[1]) bus.o_alloc_preg[1] <= preg1;

            bus.o_prf_we <= wr;
            for (int s = 0; s < 2; s++) begin
                if (wr[s]) begin
                    bus.o_prf_waddr[s] <= bus.i_retire_rob_rows[s].PRegAddrDst;
                    bus.o_prf_wdata[s] <= bus.i_retire_rob_rows[s].data;
                end
            end

            if (drop) bus.o_overflow <= 1'b1;
            bus.o_retired_total <= bus.o_retired_total + 32'(live[0]) + 32'(live[1]);
        end
    end

    assign bus.o_free_count = count;
endmodule

// File: tb/tb_retire_free_list.sv
// Bench for retire_free_list: constant-expectation vector table, then FIFO-model
// driven sequences for drain, pointer wrap, overflow and mid-traffic reset.
module tb_retire_free_list;
    import retire_free_list_pkg::*;

    typedef struct packed {
        logic [1:0]  valid;
        logic [5:0]  preg0, preg1;
        logic [1:0]  we;
        logic [5:0]  waddr0;
        logic [31:0] wdata0;
        logic [5:0]  waddr1;
        logic [31:0] wdata1;
        logic [6:0]  cnt;
        logic        ovf;
        logic [31:0] total;
    } exp_t;

    typedef struct {
        logic [1:0]    req;
        rob_row_struct r0, r1;
        exp_t          e;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    retire_free_list_if #(.PREG_W(6)) bus ();
    retire_free_list #(.NUM_PREGS(64), .NUM_ARCH(32), .PREG_W(6)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    exp_t        exp_q [$];
    logic [5:0]  mq [$];
    logic [5:0]  m_wa [2];
    logic [31:0] m_wd [2];
    logic        m_ovf;
    logic [31:0] m_total;

    function automatic rob_row_struct mk(logic v, logic c, logic rw, int dst, int old, logic [31:0] d);
        rob_row_struct r;
        r = '0;
        r.valid = v; r.complete = c; r.RegWrite = rw;
        r.PRegAddrDst = 6'(dst); r.OldPRegAddrDst = 6'(old); r.data = d;
        return r;
    endfunction

    function automatic exp_t mkx(logic [1:0] v, int p0, int p1, logic [1:0] we, int wa0,
                                 logic [31:0] wd0, int wa1, logic [31:0] wd1, int cnt,
                                 logic ovf, int total);
        exp_t e;
        e.valid = v; e.preg0 = 6'(p0); e.preg1 = 6'(p1); e.we = we;
        e.waddr0 = 6'(wa0); e.wdata0 = wd0; e.waddr1 = 6'(wa1); e.wdata1 = wd1;
        e.cnt = 7'(cnt); e.ovf = ovf; e.total = 32'(total);
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic check_out(exp_t e);
        chk("alloc_valid", 32'(bus.o_alloc_valid), 32'(e.valid));
        if (e.valid[0]) chk("alloc_preg0", 32'(bus.o_alloc_preg[0]), 32'(e.preg0));
        if (e.valid[1]) chk("alloc_preg1", 32'(bus.o_alloc_preg[1]), 32'(e.preg1));
        chk("prf_we", 32'(bus.o_prf_we), 32'(e.we));
        chk("prf_waddr0", 32'(bus.o_prf_waddr[0]), 32'(e.waddr0));
        chk("prf_wdata0", bus.o_prf_wdata[0], e.wdata0);
        chk("prf_waddr1", 32'(bus.o_prf_waddr[1]), 32'(e.waddr1));
        chk("prf_wdata1", bus.o_prf_wdata[1], e.wdata1);
        chk("free_count", 32'(bus.o_free_count), 32'(e.cnt));
        chk("overflow", 32'(bus.o_overflow), 32'(e.ovf));
        chk("retired_total", bus.o_retired_total, e.total);
    endtask

    // Reference: plain FIFO of free registers, pops before pushes, capped at 64.
    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mq.push_back(6'(32 + i));
        m_wa[0] = '0; m_wa[1] = '0; m_wd[0] = '0; m_wd[1] = '0;
        m_ovf = 1'b0; m_total = '0;
    endfunction

    function automatic void predict(input logic [1:0] req, input rob_row_struct r0,
                                    input rob_row_struct r1, output exp_t e);
        rob_row_struct rr [2];
        logic g0, g1, live, wr;
        int n;
        rr[0] = r0; rr[1] = r1;
        e = '0;
        n = mq.size();
        g0 = req[0] && (n >= 1);
        g1 = req[1] && (n >= (g0 ? 2 : 1));
        if (g0) e.preg0 = mq.pop_front();
        if (g1) e.preg1 = mq.pop_front();
        e.valid = {g1, g0};
        for (int i = 0; i < 2; i++) begin
            live = (rr[i].valid === 1'b1) && (rr[i].complete === 1'b1);
            wr = live && (rr[i].RegWrite === 1'b1);
            if (live) m_total++;
            e.we[i] = wr;
            if (wr) begin
                m_wa[i] = rr[i].PRegAddrDst;
                m_wd[i] = rr[i].data;
                if (rr[i].OldPRegAddrDst != 0) begin
                    if (mq.size() < 64) mq.push_back(rr[i].OldPRegAddrDst);
                    else m_ovf = 1'b1;
                end
            end
        end
        e.waddr0 = m_wa[0]; e.wdata0 = m_wd[0]; e.waddr1 = m_wa[1]; e.wdata1 = m_wd[1];
        e.cnt = 7'(mq.size()); e.ovf = m_ovf; e.total = m_total;
    endfunction

    task automatic step(input logic [1:0] req, input rob_row_struct r0, input rob_row_struct r1,
                        input exp_t e);
        bus.i_alloc_req = req;
        bus.i_retire_rob_rows[0] = r0;
        bus.i_retire_rob_rows[1] = r1;
        exp_q.push_back(e);
        @(posedge i_clk); #1;
        check_out(exp_q.pop_front());
    endtask

    task automatic mstep(input logic [1:0] req, input rob_row_struct r0, input rob_row_struct r1);
        exp_t e;
        predict(req, r0, r1, e);
        step(req, r0, r1, e);
    endtask

    task automatic do_reset(input logic [1:0] req, input rob_row_struct r0, input rob_row_struct r1);
        i_rst_n = 1'b0;
        bus.i_alloc_req = req;
        bus.i_retire_rob_rows[0] = r0;
        bus.i_retire_rob_rows[1] = r1;
        @(posedge i_clk); #1;
        check_out(mkx(2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 32, 1'b0, 0));
        i_rst_n = 1'b1;
        model_reset();
    endtask

    vec_t tbl [6];
    rob_row_struct idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0);
        tbl[0] = '{req: 2'b11, r0: idle, r1: idle,
                   e: mkx(2'b11, 32, 33, 2'b00, 0, 0, 0, 0, 30, 0, 0)};
        tbl[1] = '{req: 2'b00, r0: mk(1, 1, 1, 40, 5, 32'hDEAD), r1: idle,
                   e: mkx(2'b00, 0, 0, 2'b01, 40, 32'hDEAD, 0, 0, 31, 0, 1)};
        tbl[2] = '{req: 2'b00, r0: mk(1, 0, 1, 41, 6, 32'h1111), r1: mk(1'bx, 1, 1, 44, 11, 32'h2222),
                   e: mkx(2'b00, 0, 0, 2'b00, 40, 32'hDEAD, 0, 0, 31, 0, 1)};
        tbl[3] = '{req: 2'b00, r0: mk(1, 1, 1, 42, 0, 32'h1234), r1: idle,
                   e: mkx(2'b00, 0, 0, 2'b01, 42, 32'h1234, 0, 0, 31, 0, 2)};
        tbl[4] = '{req: 2'b00, r0: mk(1, 1, 0, 50, 9, 32'h9), r1: mk(1, 1, 1, 43, 10, 32'h55),
                   e: mkx(2'b00, 0, 0, 2'b10, 42, 32'h1234, 43, 32'h55, 32, 0, 4)};
        tbl[5] = '{req: 2'b10, r0: idle, r1: idle,
                   e: mkx(2'b10, 0, 34, 2'b00, 42, 32'h1234, 43, 32'h55, 31, 0, 4)};

        do_reset(2'b00, idle, idle);
        for (int i = 0; i < 6; i++) step(tbl[i].req, tbl[i].r0, tbl[i].r1, tbl[i].e);

        // Drain to a single free entry, then free p7 while both slots request.
        do_reset(2'b11, mk(1, 1, 1, 3, 4, 32'h7), idle);
        for (int k = 0; k < 40 && mq.size() > 1; k++)
            mstep(mq.size() >= 3 ? 2'b11 : 2'b01, idle, idle);
        chk("drained_to_one", 32'(bus.o_free_count), 32'd1);
        mstep(2'b11, mk(1, 1, 1, 20, 7, 32'hA7), idle);
        mstep(2'b11, idle, idle);
        chk("p7_granted_next", 32'(bus.o_alloc_preg[0]), 32'd7);
        mstep(2'b11, idle, idle);

        // Mixed traffic carries head and tail across index 63 -> 0.
        for (int k = 0; k < 80; k++) begin
            logic [1:0] rq;
            rq = 2'($urandom_range(0, 3));
            mstep(rq, mk(1'($urandom_range(0, 1)), 1, 1, k % 64, ((2 * k) % 63) + 1, 32'(k)),
                      mk(1, 1, 1, (k + 7) % 64, ((2 * k + 1) % 63) + 1, 32'(k * 3)));
        end

        // Fill completely, then two more pushes with no pops must both be dropped.
        for (int k = 0; k < 80 && mq.size() < 64; k++)
            mstep(2'b00, mk(1, 1, 1, 1, (k % 63) + 1, 32'(k)), idle);
        chk("list_full", 32'(bus.o_free_count), 32'd64);
        mstep(2'b00, mk(1, 1, 1, 2, 12, 32'h1), mk(1, 1, 1, 3, 13, 32'h2));
        chk("overflow_set", 32'(bus.o_overflow), 32'd1);
        mstep(2'b00, idle, idle);
        mstep(2'b01, idle, idle);

        // Reset under load restores the boot mapping and clears the sticky flag.
        do_reset(2'b11, mk(1, 1, 1, 5, 6, 32'h3), mk(1, 1, 1, 7, 8, 32'h4));
        step(2'b11, idle, idle, mkx(2'b11, 32, 33, 2'b00, 0, 0, 0, 0, 30, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
